// File: rtl/prince_pkg.sv
// Shared constants and types for the masked PRINCE key-extension block.
//   KEY_W  : width of one PRINCE key share (k0 || k1)
//   EXT_W  : width of one extended key share (k1 || k0' || k0)
//   ALPHA  : PRINCE reflection constant, folded into k1 for decryption
//   state_t: control FSM states of prince_key_extend_masked
package prince_pkg;

  localparam int unsigned KEY_W = 128;
  localparam int unsigned EXT_W = 192;
  localparam logic [63:0] ALPHA = 64'hC0AC29B7C97C50DD;

  typedef enum logic [1:0] {
    LOAD,
    EXPAND,
    VALID
  } state_t;

endpackage

// File: rtl/prince_key_extend_share.sv
// Combinational key extension for a single Boolean share.
// Ports:
//   key       in  [127:0] share key, [127:64]=k0, [63:0]=k1
//   dec       in          1 = decryption ordering
//   is_share0 in          this instance handles share 0 (only it absorbs ALPHA)
//   ext       out [191:0] [63:0]=first k0 slot, [127:64]=second, [191:128]=k1 term
// The map is linear, so applying it share-wise preserves the masking;
// the affine ALPHA term must be added in exactly one share.
module prince_key_extend_share
  import prince_pkg::*;
(
  input  logic [KEY_W-1:0] key,
  input  logic             dec,
  input  logic             is_share0,
  output logic [EXT_W-1:0] ext
);

  logic [63:0] k0;
  logic [63:0] k1;
  logic [63:0] k0p;
  logic [63:0] k1x;

  always_comb begin
    k0  = key[127:64];
    k1  = key[63:0];
    k0p = {k0[0], k0[63:1]} ^ {63'd0, k0[63]};
    k1x = (dec && is_share0) ? (k1 ^ ALPHA) : k1;
    ext = dec ? {k1x, k0, k0p} : {k1x, k0p, k0};
  end

endmodule

// File: rtl/prince_key_extend_masked.sv
// Sequential, N-share masked PRINCE key extension.
// Collects a 128-bit key per share over BEATS = 128/BUS_W valid/ready beats
// (MSB-first), then registers the 192-bit extended key of every share.
// Ports:
//   clk, rst            clock (rising edge), async active-high reset
//   in_valid/in_ready   input beat handshake
//   in_data             one BUS_W word per share, share i at [i*BUS_W +: BUS_W]
//   in_dec              mode, sampled on the first beat of a key
//   out_valid/out_ready extended-key handshake
//   out_key             share i at [i*192 +: 192]
//   out_dec             mode latched with out_key
module prince_key_extend_masked
  import prince_pkg::*;
#(
  parameter int unsigned SHARES = 5,
  parameter int unsigned BUS_W  = 32
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      in_valid,
  output logic                      in_ready,
  input  logic [SHARES*BUS_W-1:0]   in_data,
  input  logic                      in_dec,
  output logic                      out_valid,
  input  logic                      out_ready,
  output logic [SHARES*EXT_W-1:0]   out_key,
  output logic                      out_dec
);

  localparam int unsigned BEATS = KEY_W / BUS_W;
  localparam int unsigned CNT_W = (BEATS > 1) ? $clog2(BEATS) : 1;

  if ((KEY_W % BUS_W) != 0 || SHARES < 2) begin : g_param_check
    $error("prince_key_extend_masked: BUS_W must divide 128 and SHARES must be >= 2");
  end

  state_t                         state_q, state_d;
  logic [CNT_W-1:0]               cnt_q;
  logic                           dec_q;
  logic [SHARES-1:0][KEY_W-1:0]   key_q;
  logic [SHARES*EXT_W-1:0]        ext_all;
  logic [SHARES*EXT_W-1:0]        out_key_q;
  logic                           out_dec_q;
  logic                           beat;
  logic                           last_beat;

  assign beat      = in_valid && in_ready;
  assign last_beat = (cnt_q == CNT_W'(BEATS - 1));

  for (genvar s = 0; s < SHARES; s++) begin : g_share
    prince_key_extend_share u_share (
      .key       (key_q[s]),
      .dec       (dec_q),
      .is_share0 (s == 0),
      .ext       (ext_all[s*EXT_W +: EXT_W])
    );
  end

  always_comb begin
    state_d   = state_q;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    unique case (state_q)
      LOAD: begin
        in_ready = 1'b1;
        if (in_valid && last_beat) state_d = EXPAND;
      end
      EXPAND: state_d = VALID;
      VALID: begin
        out_valid = 1'b1;
        if (out_ready) state_d = LOAD;
      end
      default: state_d = LOAD;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= LOAD;
      cnt_q     <= '0;
      dec_q     <= 1'b0;
      key_q     <= '0;
      out_key_q <= '0;
      out_dec_q <= 1'b0;
    end else begin
      state_q <= state_d;
      if (beat) begin
        cnt_q <= last_beat ? '0 : cnt_q + CNT_W'(1);
        if (cnt_q == '0) dec_q <= in_dec;
        // Shift-in keeps beat 0 in the MSBs once all beats have arrived.
        for (int unsigned s = 0; s < SHARES; s++) begin
          key_q[s] <= (key_q[s] << BUS_W) | KEY_W'(in_data[s*BUS_W +: BUS_W]);
        end
      end
      if (state_q == EXPAND) begin
        out_key_q <= ext_all;
        out_dec_q <= dec_q;
      end
    end
  end

  assign out_key = out_key_q;
  assign out_dec = out_dec_q;

endmodule

// File: doc/prince_key_extend_masked.md
# prince_key_extend_masked

Parametrised, sequential successor to the combinational PRINCE key-extension stage. It accepts an N-share Boolean-masked 128-bit PRINCE key over a narrow valid/ready bus, beat by beat. It then produces the registered 192-bit extended key (k0, k0', k1) per share, with optional decryption-mode key ordering. It sits between the key-share source (PRNG/loader) and the masked PRINCE round datapath.

## Interface
- SHARES, 5, number of Boolean shares (≥2)
- BUS_W, 32, bits per share per input beat; must divide 128; BEATS = 128/BUS_W
- clk  in  1  clock, rising edge
- rst  in  1  asynchronous, active-high reset
- in_valid  in  1  input beat valid
- in_ready  out  1  block can accept a beat
- in_data  in  SHARES*BUS_W  one word per share; share i at [i*BUS_W +: BUS_W]
- in_dec  in  1  mode, sampled on the first beat only (1 = decryption)
- out_valid  out  1  extended key available
- out_ready  in  1  consumer accepts the extended key
- out_key  out  SHARES*192  share i at [i*192 +: 192]; per share: [63:0]=k0, [127:64]=k0', [191:128]=k1
- out_dec  out  1  mode latched with this key

## Operation
- Per-share key register of 128 bits, loaded MSB-first: beat 0 carries bits [127:128-BUS_W], and the last beat carries [BUS_W-1:0]. Bits [127:64] are k0; bits [63:0] are k1.
- Beat counter 0..BEATS-1. A beat transfers when in_valid && in_ready. The counter wraps to 0 after the last beat.
- Per share, linear map: k0' = ror1(k0) ^ (k0 >> 63), i.e. {k0[0],k0[63:1]} with k0[63] XORed into bit 0.
- Encryption (dec=0): out = {k1, k0', k0} per share.
- Decryption (dec=1): k0 and k0' swap positions. Share 0 only gets k1 ^ ALPHA (ALPHA = 0xC0AC29B7C97C50DD). Other shares pass k1 unchanged. No share ever combines with another share.
- FSM:
  - LOAD: in_ready=1. On the last-beat transfer, go to EXPAND.
  - EXPAND: in_ready=0. Register out_key and out_dec from the key register. Go to VALID.
  - VALID: out_valid=1. On out_ready, go to LOAD.
- In EXPAND and VALID, in_valid is ignored; no beat is consumed.
- out_key and out_dec hold stable while out_valid=1 and out_ready=0.
- After a VALID handshake, out_key keeps its last value until the next EXPAND; consumers must use out_valid.

## Timing
- Reset (async assert, sync release): state=LOAD, beat counter=0, key register=0, out_key=0, out_dec=0, out_valid=0, in_ready=1 in the first cycle after release.
- Latency: out_valid rises 2 cycles after the clock edge that accepts the last beat.
- Minimum period per key: BEATS + 2 cycles, when out_ready is held 1.
- in_ready drops in the cycle after the last-beat transfer. It returns to 1 in the cycle after the out_valid&&out_ready handshake.
- Back-to-back keys: beat 0 of the next key may transfer in the cycle immediately after the output handshake.
- Reset mid-load discards the partial key. Reset in VALID drops out_valid immediately (asynchronously).
- Gaps (in_valid=0) inside a load are allowed. The counter and the latched mode hold across gaps.

## Structure
- Package prince_pkg holds:
  - KEY_W=128, EXT_W=192, ALPHA
  - the FSM state enum (LOAD, EXPAND, VALID)
- Sub-module prince_key_extend_share: combinational, one share, inputs key[127:0], dec, is_share0; output ext[191:0]. The top instantiates it SHARES times.
- The top module holds the FSM, the beat counter, the shift/key registers and the output registers.
- Elaboration-time check: 128 % BUS_W == 0 and SHARES ≥ 2.

## Test plan
Defaults for all scenarios: SHARES=5, BUS_W=32, 4 beats.
- Unmasked encryption: share0 key = k0 0x0000000000000001, k1 0x0; other shares zero. Expect share0 k0'=0x8000000000000000, k1=0, and other shares all zero, out_valid at last-beat edge +2.
- MSB wrap: k0=0x8000000000000000 in share0 → k0'=0x4000000000000001.
- Masked key: share1 = random R, share0 = K ^ R, shares 2–4 random with XOR compensated in share0. Check that the XOR of all out_key shares equals the unmasked extension of K. Check that every share equals the per-share map of its own input.
- Decryption: k0=0x0123456789ABCDEF, k1=0. Expect out_dec=1, positions k0/k0' swapped, and XOR of the k1 shares = 0xC0AC29B7C97C50DD.
- Backpressure and gaps:
  - hold out_ready=0 for 10 cycles → out_key stable, in_ready=0, in_valid pulses ignored;
  - in_valid gaps between beats → same result as a gapless load;
  - back-to-back keys → next beat accepted the cycle after the handshake.
- Reset mid-load after 2 beats, then a full load of a new key → output matches the new key only; all outputs are 0 immediately after reset.
